// File: rtl/sipo_frame_ctrl_pkg.sv
// Package sipo_ctrl_pkg: shared types and defaults for the SIPO frame controller.
//   sipo_state_e   : FSM state encoding. PARITY is used only when SIPO_PARITY_CHECK_EN is defined.
//   SIPO_DEF_WIDTH : default number of data bits per frame.
package sipo_ctrl_pkg;

  localparam int SIPO_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_e;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if: groups the serial input, control strobes and the parallel
// valid/ready port of the SIPO frame controller.
//   master : bit source / consumer side (drives start, s_valid, s_in, p_ready, clr_ovr)
//   slave  : controller side (drives p_out, p_valid, busy, overrun, parity_err)
interface sipo_frame_ctrl_if
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_DEF_WIDTH
);
  logic             start;
  logic             s_valid;
  logic             s_in;
  logic             p_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output start, s_valid, s_in, p_ready, clr_ovr,
    input  p_out, p_valid, busy, overrun, parity_err
  );

  modport slave (
    input  start, s_valid, s_in, p_ready, clr_ovr,
    output p_out, p_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: WIDTH-bit left-shift register, MSB received first.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear (has priority over shift_en)
//   shift_en  : shift s_in into bit 0
//   s_in      : serial input bit
//   q         : register contents
module sipo_shift_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             s_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (clr) begin
      shreg_d = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], s_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign q = shreg_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial-in/parallel-out receive controller. Sequences the
// shift core, counts bits per frame and hands completed words to a one-entry
// valid/ready output buffer with sticky overrun detection.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sipo_frame_ctrl_if slave modport (serial in, strobes, parallel out)
// Optional feature macro: SIPO_PARITY_CHECK_EN adds an even-parity bit after
// the data bits; a bad parity bit drops the word and pulses parity_err.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for start
// SHIFT  | collecting data bits, count = bits received so far
// PARITY | data complete, waiting for the parity bit (macro build only)
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  sipo_frame_ctrl_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sipo_state_e      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             p_valid_q, p_valid_d;
  logic             overrun_q, overrun_d;

  logic             sh_clr;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_q;
  logic             word_done;
  logic [WIDTH-1:0] word;

  sipo_shift_core #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (sh_clr),
    .shift_en (sh_shift),
    .s_in     (bus.s_in),
    .q        (sh_q)
  );

`ifdef SIPO_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;

  // The last data bit has already been shifted in when the parity bit arrives.
  assign word = sh_q;
`else
  logic shreg_msb_unused;

  // Word is delivered on the edge that samples the last bit, so splice it in here.
  assign word             = {sh_q[WIDTH-2:0], bus.s_in};
  assign shreg_msb_unused = sh_q[WIDTH-1];
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sh_clr    = 1'b0;
    sh_shift  = 1'b0;
    word_done = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          count_d = '0;
          sh_clr  = 1'b1;
        end
      end

      SHIFT: begin
        if (bus.start) begin
          // Restart discards the partial word and any same-cycle bit.
          count_d = '0;
          sh_clr  = 1'b1;
        end else if (bus.s_valid) begin
          sh_shift = 1'b1;
          if (count_q == LAST_BIT) begin
            count_d = '0;
`ifdef SIPO_PARITY_CHECK_EN
            state_d = PARITY;
`else
            state_d   = IDLE;
            word_done = 1'b1;
`endif
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

`ifdef SIPO_PARITY_CHECK_EN
      PARITY: begin
        if (bus.start) begin
          state_d = SHIFT;
          count_d = '0;
          sh_clr  = 1'b1;
        end else if (bus.s_valid) begin
          state_d = IDLE;
          if ((^sh_q) ^ bus.s_in) begin
            parity_err_d = 1'b1;
          end else begin
            word_done = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output buffer: a completed word may load when the buffer is empty or is
  // being drained this same cycle; otherwise it is dropped and flagged.
  always_comb begin
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    overrun_d = overrun_q;

    if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end

    if (p_valid_q && bus.p_ready) begin
      p_valid_d = 1'b0;
    end

    if (word_done) begin
      if (!p_valid_q || bus.p_ready) begin
        p_out_d   = word;
        p_valid_d = 1'b1;
      end else begin
        // Drop wins over a coincident clear.
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.p_out   = p_out_q;
  assign bus.p_valid = p_valid_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;
  import sipo_ctrl_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;

  sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.p_valid && bus.p_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", 32'(bus.p_out), 32'hFFFF_FFFF);
      end else begin
        check("word", 32'(bus.p_out), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.s_valid = 1'b1;
    bus.s_in    = b;
    tick();
    bus.s_valid = 1'b0;
  endtask

  // Sends a data word MSB first (plus even parity in the parity build).
  task automatic send_frame(input logic [W-1:0] w, input bit gap, input bit clr_last, input bit chk_lat);
    logic [W:0] seq;
    int lo;
    seq = {w, ^w};
`ifdef SIPO_PARITY_CHECK_EN
    lo = 0;
`else
    lo = 1;
`endif
    for (int i = W; i >= lo; i--) begin
      if (i == lo) begin
        if (chk_lat) check("valid_before_last", 32'(bus.p_valid), 32'd0);
        bus.clr_ovr = clr_last;
      end
      send_bit(seq[i]);
      bus.clr_ovr = 1'b0;
      if (gap && i != lo) begin
        bus.s_in = ~seq[i];
        tick();
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_in    = 1'b0;
    bus.p_ready = 1'b0;
    bus.clr_ovr = 1'b0;

    // 1: reset state
    tick();
    tick();
    check("rst_p_out", 32'(bus.p_out), 32'd0);
    check("rst_p_valid", 32'(bus.p_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_parity_err", 32'(bus.parity_err), 32'd0);
    rst = 1'b0;
    tick();

    // 2: back-to-back bits, latency and busy
    bus.p_ready = 1'b1;
    sb_q.push_back(8'hB2);
    start_frame();
    check("busy_in_frame", 32'(bus.busy), 32'd1);
    send_frame(8'hB2, 1'b0, 1'b0, 1'b1);
    check("valid_after_last", 32'(bus.p_valid), 32'd1);
    check("p_out_b2", 32'(bus.p_out), 32'hB2);
    check("busy_after_frame", 32'(bus.busy), 32'd0);
    tick();
    check("valid_cleared", 32'(bus.p_valid), 32'd0);

    // 3: s_valid gaps with toggling s_in
    sb_q.push_back(8'hB2);
    start_frame();
    send_frame(8'hB2, 1'b1, 1'b0, 1'b1);
    check("gap_p_out", 32'(bus.p_out), 32'hB2);
    check("gap_busy", 32'(bus.busy), 32'd0);
    tick();

    // 4: overrun, clear, drop-vs-clear priority, drain
    bus.p_ready = 1'b0;
    sb_q.push_back(8'hB2);
    start_frame();
    send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
    start_frame();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    check("ovr_set", 32'(bus.overrun), 32'd1);
    check("ovr_p_out_held", 32'(bus.p_out), 32'hB2);
    check("ovr_p_valid", 32'(bus.p_valid), 32'd1);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    check("ovr_cleared", 32'(bus.overrun), 32'd0);
    start_frame();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check("ovr_drop_wins", 32'(bus.overrun), 32'd1);
    check("ovr_p_out_held2", 32'(bus.p_out), 32'hB2);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    check("ovr_cleared2", 32'(bus.overrun), 32'd0);
    bus.p_ready = 1'b1;
    tick();
    check("drain_valid", 32'(bus.p_valid), 32'd0);

    // 5: restart mid-frame, then reset mid-frame
    sb_q.push_back(8'hC3);
    start_frame();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    bus.s_valid = 1'b1;
    bus.s_in    = 1'b1;
    start_frame();
    bus.s_valid = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    check("restart_p_out", 32'(bus.p_out), 32'hC3);
    tick();
    start_frame();
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_valid", 32'(bus.p_valid), 32'd0);
    check("rst_mid_p_out", 32'(bus.p_out), 32'd0);
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    check("idle_ignores_bits", 32'(bus.p_valid), 32'd0);

`ifdef SIPO_PARITY_CHECK_EN
    // 6: parity good and bad
    sb_q.push_back(8'hB2);
    start_frame();
    send_frame(8'hB2, 1'b0, 1'b0, 1'b1);
    check("par_ok_valid", 32'(bus.p_valid), 32'd1);
    check("par_ok_err", 32'(bus.parity_err), 32'd0);
    tick();
    start_frame();
    for (int i = W - 1; i >= 0; i--) begin
      logic [W-1:0] v;
      v = 8'hB2;
      send_bit(v[i]);
    end
    send_bit(1'b1);
    check("par_bad_err", 32'(bus.parity_err), 32'd1);
    check("par_bad_valid", 32'(bus.p_valid), 32'd0);
    check("par_bad_ovr", 32'(bus.overrun), 32'd0);
    tick();
    check("par_err_pulse", 32'(bus.parity_err), 32'd0);
`endif

    repeat (4) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
